// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs. buffered MDU results, with anti-starvation stall.
// Optional stall/drop statistics outputs are enabled by defining RF_WB_STATS_EN.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_idx,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_idx,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_widx,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count, w_count_next;
  logic [7:0]      r_starve, w_starve_next;
  logic [4:0]      r_idx_mem  [FIFO_DEPTH];
  logic [31:0]     r_data_mem [FIFO_DEPTH];

  logic            w_empty, w_full, w_push, w_pop, w_pipe_write;
  logic [FIFO_DEPTH-1:0] w_entry_valid;
  logic [31:0]     w_pend;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (PW+1)'(FIFO_DEPTH));
  assign mdu_ready    = !reset && !w_full;
  // Destination x0 is accepted from the MDU but never stored.
  assign w_push       = mdu_valid && mdu_ready && (mdu_idx != 5'd0);
  assign w_pipe_write = !reset && (r_state == ST_NORMAL) && pipe_valid && (pipe_idx != 5'd0);
  assign w_pop        = !reset && !w_empty && ((r_state == ST_FORCE) || !w_pipe_write);
  assign w_count_next = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_NORMAL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_starve <= w_starve_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_idx_mem[r_wr_ptr]  <= mdu_idx;
      r_data_mem[r_wr_ptr] <= mdu_data;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = '0;
    pipe_ready    = 1'b1;
    rf_we         = 1'b0;
    rf_widx       = '0;
    rf_wdata      = '0;
    if (!reset) begin
      if (w_pipe_write) begin
        rf_we    = 1'b1;
        rf_widx  = pipe_idx;
        rf_wdata = pipe_data;
      end else if (w_pop) begin
        rf_we    = 1'b1;
        rf_widx  = r_idx_mem[r_rd_ptr];
        rf_wdata = r_data_mem[r_rd_ptr];
      end
      case (r_state)
        ST_NORMAL: begin
          if (!w_empty && !w_pop) w_starve_next = r_starve + 8'd1;
          if ((w_count_next == (PW+1)'(FIFO_DEPTH)) || (w_starve_next == 8'(STARVE_LIMIT)))
            w_state_next = ST_FORCE;
        end
        ST_FORCE: begin
          pipe_ready = 1'b0;
          if (w_count_next < (PW+1)'(FIFO_DEPTH) || w_count_next == '0)
            w_state_next = ST_NORMAL;
        end
        default: w_state_next = ST_NORMAL;
      endcase
    end
  end

  // Slot gi holds a live entry when its distance from the head is below count.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_valid
    logic [PW-1:0] w_off;
    assign w_off             = PW'(gi) - r_rd_ptr;
    assign w_entry_valid[gi] = ({1'b0, w_off} < r_count);
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i]) w_pend[r_idx_mem[i]] = 1'b1;
    end
  end

  assign pend_mask = reset ? 32'd0 : w_pend;

`ifdef RF_WB_STATS_EN
  logic [15:0] r_stall_cnt, r_drop_cnt;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;

  assign w_drop_inc = {1'b0, !reset && pipe_valid && pipe_ready && (pipe_idx == 5'd0)}
                    + {1'b0, mdu_valid && mdu_ready && (mdu_idx == 5'd0)};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (!pipe_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=4).
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_ready, mdu_valid, mdu_ready, rf_we;
  logic [4:0]  pipe_idx, mdu_idx, rf_widx;
  logic [31:0] pipe_data, mdu_data, rf_wdata, pend_mask;
`ifdef RF_WB_STATS_EN
  logic [15:0] stall_cnt, drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_idx(pipe_idx), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .mdu_valid(mdu_valid), .mdu_idx(mdu_idx), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_widx(rf_widx), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
`ifdef RF_WB_STATS_EN
    , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] idx, input logic [31:0] d);
    pipe_valid = v; pipe_idx = idx; pipe_data = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] idx, input logic [31:0] d);
    mdu_valid = v; mdu_idx = idx; mdu_data = d;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] idx, input logic [31:0] d);
    check({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      check({tag, ".idx"}, {27'd0, rf_widx}, {27'd0, idx});
      check({tag, ".data"}, rf_wdata, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_pipe(1'b1, 5'd5, 32'h55);
    drive_mdu(1'b1, 5'd3, 32'h33);
    step(); step();
    settle();
    // Outputs held quiet during reset regardless of inputs.
    check("rst.we", {31'd0, rf_we}, 32'd0);
    check("rst.widx", {27'd0, rf_widx}, 32'd0);
    check("rst.wdata", rf_wdata, 32'd0);
    check("rst.mdu_ready", {31'd0, mdu_ready}, 32'd0);
    check("rst.pipe_ready", {31'd0, pipe_ready}, 32'd1);
    check("rst.pend", pend_mask, 32'd0);

    // Pipeline write, zero latency.
    reset = 1'b0;
    drive_pipe(1'b1, 5'd5, 32'h000000A5);
    drive_mdu(1'b0, 5'd0, 32'd0);
    settle();
    check("pipe.ready", {31'd0, pipe_ready}, 32'd1);
    check_write("pipe", 1'b1, 5'd5, 32'hA5);
    step();

    // MDU single entry: enqueue, then write next cycle.
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b1, 5'd7, 32'h1234);
    settle();
    check("mdu.ready", {31'd0, mdu_ready}, 32'd1);
    check_write("mdu.enq", 1'b0, 5'd0, 32'd0);
    step();
    drive_mdu(1'b0, 5'd0, 32'd0);
    settle();
    check("mdu.pend", pend_mask, 32'h80);
    check_write("mdu.wr", 1'b1, 5'd7, 32'h1234);
    step();
    check("mdu.pend_clr", pend_mask, 32'd0);
    check_write("mdu.idle", 1'b0, 5'd0, 32'd0);

    // Starvation: one entry, pipe busy for 4 cycles, then one forced cycle.
    drive_mdu(1'b1, 5'd9, 32'h99);
    settle();
    step();
    drive_mdu(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive_pipe(1'b1, 5'(4 + k), 32'(32'h40 + k));
      settle();
      check($sformatf("starve%0d.ready", k), {31'd0, pipe_ready}, 32'd1);
      check_write($sformatf("starve%0d", k), 1'b1, 5'(4 + k), 32'(32'h40 + k));
      step();
    end
    drive_pipe(1'b1, 5'd8, 32'h48);
    settle();
    check("force.ready", {31'd0, pipe_ready}, 32'd0);
    check_write("force", 1'b1, 5'd9, 32'h99);
    step();
    check("force.after_ready", {31'd0, pipe_ready}, 32'd1);
    check_write("force.after", 1'b1, 5'd8, 32'h48);
    check("force.after_pend", pend_mask, 32'd0);
    step();

    // Fill the FIFO while the pipe is busy.
    for (int k = 0; k < 4; k++) begin
      drive_pipe(1'b1, 5'd1, 32'(k));
      drive_mdu(1'b1, 5'(10 + k), 32'(32'hA0 + k));
      settle();
      check($sformatf("fill%0d.mdu_ready", k), {31'd0, mdu_ready}, 32'd1);
      check_write($sformatf("fill%0d", k), 1'b1, 5'd1, 32'(k));
      if (k == 3) check("fill3.pend", pend_mask, 32'h1C00);
      step();
    end
    drive_mdu(1'b1, 5'd14, 32'hA4);
    settle();
    check("full.mdu_ready", {31'd0, mdu_ready}, 32'd0);
    check("full.pipe_ready", {31'd0, pipe_ready}, 32'd0);
    check("full.pend", pend_mask, 32'h3C00);
    check_write("full.pop0", 1'b1, 5'd10, 32'hA0);
    step();
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    settle();
    check("drain.pipe_ready", {31'd0, pipe_ready}, 32'd1);
    check("drain.mdu_ready", {31'd0, mdu_ready}, 32'd1);
    check("drain.pend", pend_mask, 32'h3800);
    for (int k = 1; k < 4; k++) begin
      check_write($sformatf("drain%0d", k), 1'b1, 5'(10 + k), 32'(32'hA0 + k));
      step();
    end
    check_write("drain.empty", 1'b0, 5'd0, 32'd0);
    check("drain.pend_clr", pend_mask, 32'd0);

    // x0 handling.
    drive_mdu(1'b1, 5'd3, 32'h33);
    settle();
    step();
    drive_pipe(1'b1, 5'd0, 32'hDEAD);
    drive_mdu(1'b1, 5'd0, 32'hBEEF);
    settle();
    check("x0.pipe_ready", {31'd0, pipe_ready}, 32'd1);
    check("x0.mdu_ready", {31'd0, mdu_ready}, 32'd1);
    check("x0.pend", pend_mask, 32'h8);
    check_write("x0.fifo", 1'b1, 5'd3, 32'h33);
    step();
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    settle();
    check_write("x0.after", 1'b0, 5'd0, 32'd0);
    check("x0.pend_after", pend_mask, 32'd0);

    // Reset with 3 queued entries discards them.
    for (int k = 0; k < 3; k++) begin
      drive_pipe(1'b1, 5'd1, 32'(k));
      drive_mdu(1'b1, 5'(20 + k), 32'(32'hC0 + k));
      settle();
      step();
    end
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    settle();
    check("q3.pend", pend_mask, 32'h700000);
    reset = 1'b1;
    settle();
    check("q3.rst_we", {31'd0, rf_we}, 32'd0);
    check("q3.rst_pend", pend_mask, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("q3.post%0d.we", k), {31'd0, rf_we}, 32'd0);
      check($sformatf("q3.post%0d.pend", k), pend_mask, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
